rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
- Reset sequencer for the video controller. Waits for a filtered PLL lock, holds every reset domain in reset for a fixed time, then releases per-domain active-low resets one at a time in index order.
- Example release order: SDRAM controller, framebuffer/pixel pipeline, HDMI TX.
- Before releasing the next domain, waits for the current domain's ready/ack plus a guard gap.
- Per-domain outputs are already synchronous to clk, so they feed each domain's local reset synchronizer directly.

Parameters:
- NB_DOM, 3, number of reset domains (1..8).
- LOCK_FILT, 4, consecutive cycles pll_locked must be high before sequencing (>=1).
- HOLD_CYC, 16, cycles all domains stay in reset after lock is accepted (>=1).
- GAP_CYC, 8, guard cycles between an ack and the next domain's release (>=0).
- ACK_MASK, {NB_DOM{1'b1}}, bit i=1: wait for dom_ack[i]; bit i=0: ignore dom_ack[i].
- TIMEOUT_CYC, 1024, ack watchdog limit; only used with RST_SEQ_TIMEOUT_EN.

Ports:
- clk, in, 1, system clock.
- rst_in, in, 1, synchronous active-low reset; the block is reset while rst_in=0 at a rising clk edge.
- pll_locked, in, 1, PLL lock; must already be synchronous to clk.
- dom_ack, in, NB_DOM, per-domain ready (e.g. SDRAM init done); level-sensitive.
- rst_dom_n, out, NB_DOM, per-domain reset, active low.
- sys_ready, out, 1, high once every domain is released and acked.
- cur_dom, out, $clog2(NB_DOM) (min 1), index of the domain being sequenced (debug).
- err_timeout, out, 1, sticky ack-timeout flag.

Behaviour:
- All outputs are registered. Counter widths come from $clog2(max parameter + 1).
- Reset (rst_in=0 at an edge):
  - state = WAIT_LOCK.
  - rst_dom_n = all 0; sys_ready = 0; cur_dom = 0; err_timeout = 0; all counters = 0.
- Priority at every edge: rst_in low > lock loss > normal transitions.
- Lock loss: pll_locked=0 in any state other than WAIT_LOCK. Next edge:
  - rst_dom_n = all 0; sys_ready = 0; cur_dom = 0.
  - state = WAIT_LOCK; err_timeout is kept.
- WAIT_LOCK:
  - Filter counter increments while pll_locked=1 and clears to 0 whenever pll_locked=0.
  - After LOCK_FILT consecutive high cycles -> HOLD.
- HOLD: stays exactly HOLD_CYC cycles -> RELEASE.
- RELEASE: one cycle. At exit, rst_dom_n[cur_dom] = 1 -> WAIT_ACK.
- WAIT_ACK:
  - Exits when dom_ack[cur_dom]=1 or ACK_MASK[cur_dom]=0. Minimum 1 cycle.
  - If cur_dom = NB_DOM-1 -> DONE. Otherwise -> GAP.
- GAP: stays GAP_CYC cycles, then cur_dom += 1 -> RELEASE. If GAP_CYC=0, go straight to RELEASE.
- DONE:
  - sys_ready = 1 from the first DONE cycle. rst_dom_n = all 1.
  - Stays in DONE until reset or lock loss.
  - A dom_ack deassertion in DONE is ignored.
- Released domains stay released while later domains are sequenced. Never more than one 0->1 transition per edge.
- Timing with pll_locked held high from reset release (cycle 0 = first edge with rst_in=1):
  - rst_dom_n[0] reads 1 after edge LOCK_FILT+HOLD_CYC+1. Defaults: edge 21.
  - With all acks already high, domain i+1 is released 2+GAP_CYC edges after domain i.
- Reset or lock loss mid-sequence always returns to the full sequence from domain 0. No partial resume.

Optional Feature:
- Macro RST_SEQ_TIMEOUT_EN.
- When defined:
  - In WAIT_ACK, a watchdog counts cycles without an accepted ack.
  - On reaching TIMEOUT_CYC, the next edge goes to FAULT:
    - rst_dom_n = all 0; cur_dom = 0; err_timeout = 1.
    - err_timeout is sticky and clears only on rst_in.
  - FAULT lasts one cycle, then HOLD, re-running the sequence with the lock still held.
  - The watchdog clears when entering each WAIT_ACK.
- When undefined: no watchdog logic; WAIT_ACK waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Defaults; pll_locked=1 and dom_ack=3'b111 from cycle 0:
  - rst_dom_n goes 000 -> 001 at edge 21, 011 at 31, 111 at 41.
  - sys_ready=1 at edge 42.
- pll_locked pulses high 3 cycles, low 1, then stays high:
  - HOLD is entered only after 4 further consecutive high cycles.
  - rst_dom_n[0] rises 4 cycles later than in the first test.
- dom_ack[0] held 0 for 50 cycles after release:
  - rst_dom_n stays 001 and cur_dom=0.
  - Raising dom_ack[0] gives rst_dom_n[1] rising 2+GAP_CYC=10 edges later.
- pll_locked drops while cur_dom=2:
  - Next edge: rst_dom_n=000, sys_ready=0, cur_dom=0.
  - After lock returns, the full sequence is re-run with the first-test timing relative to the lock return.
- rst_in=0 for one cycle in DONE: rst_dom_n=000 and sys_ready=0 after that edge; the sequence restarts.
- RST_SEQ_TIMEOUT_EN, TIMEOUT_CYC=32, dom_ack[1] stuck at 0:
  - err_timeout=1 and rst_dom_n=000 after 32 WAIT_ACK cycles.
  - Sequence restarts from HOLD; err_timeout stays 1 until rst_in.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: filters PLL lock, holds all domains in reset, then releases them one by one.
// Optional ack watchdog enabled by defining RST_SEQ_TIMEOUT_EN.
//
// state     | meaning
// WAIT_LOCK | all domains in reset, filtering pll_locked
// HOLD      | lock accepted, holding all domains for HOLD_CYC cycles
// RELEASE   | one cycle; releases domain cur_dom on exit
// WAIT_ACK  | waiting for dom_ack[cur_dom] (or masked)
// GAP       | guard cycles before the next domain's release
// DONE      | all domains released, sys_ready high
// FAULT     | ack watchdog expired; one cycle, then HOLD
module rst_seq_ctrl #(
  parameter int NB_DOM = 3,
  parameter int LOCK_FILT = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC = 8,
  parameter logic [NB_DOM-1:0] ACK_MASK = {NB_DOM{1'b1}},
  parameter int TIMEOUT_CYC = 1024,
  localparam int CD_W = (NB_DOM > 1) ? $clog2(NB_DOM) : 1
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              pll_locked,
  input  logic [NB_DOM-1:0] dom_ack,
  output logic [NB_DOM-1:0] rst_dom_n,
  output logic              sys_ready,
  output logic [CD_W-1:0]   cur_dom,
  output logic              err_timeout
);

  localparam int MAX_A = (LOCK_FILT > HOLD_CYC) ? LOCK_FILT : HOLD_CYC;
  localparam int MAX_B = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK, HOLD, RELEASE, WAIT_ACK, GAP, DONE, FAULT
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NB_DOM-1:0] rst_nxt;
  logic              rdy_nxt;
  logic [CD_W-1:0]   dom_nxt;
  logic              ack_ok;
  logic              last_dom;

  assign ack_ok   = dom_ack[cur_dom] | ~ACK_MASK[cur_dom];
  assign last_dom = (cur_dom == CD_W'(NB_DOM - 1));

`ifdef RST_SEQ_TIMEOUT_EN
  logic err_q, err_nxt;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      rst_dom_n <= '0;
      sys_ready <= 1'b0;
      cur_dom   <= '0;
`ifdef RST_SEQ_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_dom_n <= rst_nxt;
      sys_ready <= rdy_nxt;
      cur_dom   <= dom_nxt;
`ifdef RST_SEQ_TIMEOUT_EN
      err_q     <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rst_nxt   = rst_dom_n;
    rdy_nxt   = sys_ready;
    dom_nxt   = cur_dom;
`ifdef RST_SEQ_TIMEOUT_EN
    err_nxt   = err_q;
`endif
    if (state != WAIT_LOCK && !pll_locked) begin
      // Lock loss restarts the whole sequence; the timeout flag survives.
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
      rst_nxt   = '0;
      rdy_nxt   = 1'b0;
      dom_nxt   = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (!pll_locked) begin
            cnt_nxt = '0;
          end else if (cnt == CNT_W'(LOCK_FILT)) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == CNT_W'(HOLD_CYC - 1)) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RELEASE: begin
          rst_nxt   = rst_dom_n | (NB_DOM'(1) << cur_dom);
          state_nxt = WAIT_ACK;
          cnt_nxt   = '0;
        end
        WAIT_ACK: begin
          if (ack_ok) begin
            cnt_nxt = '0;
            if (last_dom) begin
              state_nxt = DONE;
              rdy_nxt   = 1'b1;
              rst_nxt   = '1;
            end else if (GAP_CYC == 0) begin
              state_nxt = RELEASE;
              dom_nxt   = cur_dom + 1'b1;
            end else begin
              state_nxt = GAP;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_nxt = FAULT;
            cnt_nxt   = '0;
            rst_nxt   = '0;
            dom_nxt   = '0;
            err_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
            dom_nxt   = cur_dom + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DONE: begin
          rst_nxt = '1;
          rdy_nxt = 1'b1;
        end
        FAULT: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          rst_nxt   = '0;
          rdy_nxt   = 1'b0;
          dom_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: timeline table plus hand sequences, checked through an expectation queue.
// Edge 0 is the first rising edge with rst_in high.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_in = 1'b0;
  logic       pll_locked = 1'b0;
  logic [2:0] dom_ack = 3'b000;
  logic [2:0] rst_dom_n;
  logic       sys_ready;
  logic [1:0] cur_dom;
  logic       err_timeout;

  rst_seq_ctrl #(.NB_DOM(3), .LOCK_FILT(4), .HOLD_CYC(16), .GAP_CYC(8),
                 .ACK_MASK(3'b111), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst_in(rst_in), .pll_locked(pll_locked), .dom_ack(dom_ack),
    .rst_dom_n(rst_dom_n), .sys_ready(sys_ready), .cur_dom(cur_dom),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] dom;
    logic       err;
  } exp_t;

  typedef struct {
    int         scen;
    int         edge_no;
    logic       lock;
    logic [2:0] ack;
    logic       chk;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] dom;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_n = 0;

  task automatic push(string name, logic [2:0] r, logic y, logic [1:0] d, logic e);
    exp_t x;
    x.name = name; x.rst = r; x.rdy = y; x.dom = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic tick(logic lk, logic [2:0] ak);
    exp_t x;
    pll_locked = lk;
    dom_ack = ak;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_chk++;
      if ({rst_dom_n, sys_ready, cur_dom, err_timeout} !== {x.rst, x.rdy, x.dom, x.err}) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got rst_dom_n=%b sys_ready=%b cur_dom=%0d err=%b, want %b %b %0d %b",
                 x.name, edge_n, rst_dom_n, sys_ready, cur_dom, err_timeout,
                 x.rst, x.rdy, x.dom, x.err);
      end
    end
    edge_n++;
  endtask

  task automatic do_reset(logic lk, logic [2:0] ak);
    rst_in = 1'b0;
    tick(lk, ak);
    push("reset_state", 3'b000, 1'b0, 2'd0, 1'b0);
    tick(lk, ak);
    rst_in = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_until(int e, logic lk, logic [2:0] ak);
    while (edge_n < e) tick(lk, ak);
  endtask

  task automatic check_at(string name, int e, logic lk, logic [2:0] ak,
                          logic [2:0] r, logic y, logic [1:0] d, logic er);
    run_until(e, lk, ak);
    push(name, r, y, d, er);
    tick(lk, ak);
  endtask

  vec_t tbl[$];

  initial begin
    logic       cur_lk;
    logic [2:0] cur_ak;
    int         scen;

    // scen 0: steady lock, all acks high; scen 1: lock glitch 3 high / 1 low
    tbl = '{
      '{0, 0,  1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0},
      '{0, 20, 1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0},
      '{0, 21, 1'b1, 3'b111, 1'b1, 3'b001, 1'b0, 2'd0},
      '{0, 29, 1'b1, 3'b111, 1'b1, 3'b001, 1'b0, 2'd0},
      '{0, 30, 1'b1, 3'b111, 1'b1, 3'b001, 1'b0, 2'd1},
      '{0, 31, 1'b1, 3'b111, 1'b1, 3'b011, 1'b0, 2'd1},
      '{0, 40, 1'b1, 3'b111, 1'b1, 3'b011, 1'b0, 2'd2},
      '{0, 41, 1'b1, 3'b111, 1'b1, 3'b111, 1'b0, 2'd2},
      '{0, 42, 1'b1, 3'b111, 1'b1, 3'b111, 1'b1, 2'd2},
      '{0, 60, 1'b1, 3'b111, 1'b1, 3'b111, 1'b1, 2'd2},
      '{1, 0,  1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 2'd0},
      '{1, 3,  1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0},
      '{1, 4,  1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 2'd0},
      '{1, 24, 1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0},
      '{1, 25, 1'b1, 3'b111, 1'b1, 3'b001, 1'b0, 2'd0},
      '{1, 35, 1'b1, 3'b111, 1'b1, 3'b011, 1'b0, 2'd1},
      '{1, 45, 1'b1, 3'b111, 1'b1, 3'b111, 1'b0, 2'd2},
      '{1, 46, 1'b1, 3'b111, 1'b1, 3'b111, 1'b1, 2'd2}
    };

    scen = -1;
    cur_lk = 1'b0;
    cur_ak = 3'b000;
    foreach (tbl[i]) begin
      if (tbl[i].scen != scen) begin
        scen = tbl[i].scen;
        do_reset(1'b0, 3'b000);
      end
      run_until(tbl[i].edge_no, cur_lk, cur_ak);
      cur_lk = tbl[i].lock;
      cur_ak = tbl[i].ack;
      if (tbl[i].chk)
        push($sformatf("tbl_s%0d_e%0d", scen, tbl[i].edge_no),
             tbl[i].rst, tbl[i].rdy, tbl[i].dom, 1'b0);
      tick(cur_lk, cur_ak);
    end

    // dom_ack[0] stalls for 50 cycles after release
    do_reset(1'b1, 3'b110);
    check_at("stall_rel0",   21, 1'b1, 3'b110, 3'b001, 1'b0, 2'd0, 1'b0);
    check_at("stall_mid",    50, 1'b1, 3'b110, 3'b001, 1'b0, 2'd0, 1'b0);
    check_at("stall_end",    71, 1'b1, 3'b110, 3'b001, 1'b0, 2'd0, 1'b0);
    check_at("stall_gapend", 80, 1'b1, 3'b111, 3'b001, 1'b0, 2'd1, 1'b0);
    check_at("stall_rel1",   81, 1'b1, 3'b111, 3'b011, 1'b0, 2'd1, 1'b0);

    // lock drops while domain 2 is being sequenced
    do_reset(1'b1, 3'b111);
    check_at("loss_pre",   40, 1'b1, 3'b111, 3'b011, 1'b0, 2'd2, 1'b0);
    check_at("loss_edge",  41, 1'b0, 3'b111, 3'b000, 1'b0, 2'd0, 1'b0);
    check_at("loss_hold",  62, 1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 1'b0);
    check_at("loss_rel0",  63, 1'b1, 3'b111, 3'b001, 1'b0, 2'd0, 1'b0);
    check_at("loss_rel1",  73, 1'b1, 3'b111, 3'b011, 1'b0, 2'd1, 1'b0);
    check_at("loss_rel2",  83, 1'b1, 3'b111, 3'b111, 1'b0, 2'd2, 1'b0);
    check_at("loss_ready", 84, 1'b1, 3'b111, 3'b111, 1'b1, 2'd2, 1'b0);

    // ack drop ignored in DONE, then a one-cycle rst_in pulse restarts everything
    do_reset(1'b1, 3'b111);
    check_at("done_ready", 42, 1'b1, 3'b111, 3'b111, 1'b1, 2'd2, 1'b0);
    check_at("done_ackdrop", 47, 1'b1, 3'b000, 3'b111, 1'b1, 2'd2, 1'b0);
    rst_in = 1'b0;
    push("done_rst_pulse", 3'b000, 1'b0, 2'd0, 1'b0);
    tick(1'b1, 3'b111);
    rst_in = 1'b1;
    edge_n = 0;
    check_at("restart_hold", 20, 1'b1, 3'b111, 3'b000, 1'b0, 2'd0, 1'b0);
    check_at("restart_rel0", 21, 1'b1, 3'b111, 3'b001, 1'b0, 2'd0, 1'b0);

`ifdef RST_SEQ_TIMEOUT_EN
    // dom_ack[1] stuck low trips the 32-cycle watchdog
    do_reset(1'b1, 3'b101);
    check_at("to_waiting", 62, 1'b1, 3'b101, 3'b011, 1'b0, 2'd1, 1'b0);
    check_at("to_fault",   63, 1'b1, 3'b101, 3'b000, 1'b0, 2'd0, 1'b1);
    check_at("to_hold",    80, 1'b1, 3'b101, 3'b000, 1'b0, 2'd0, 1'b1);
    check_at("to_rel0",    81, 1'b1, 3'b101, 3'b001, 1'b0, 2'd0, 1'b1);
    do_reset(1'b1, 3'b101);
    check_at("to_cleared", 0, 1'b1, 3'b101, 3'b000, 1'b0, 2'd0, 1'b0);
`else
    do_reset(1'b1, 3'b101);
    check_at("no_wdog", 200, 1'b1, 3'b101, 3'b011, 1'b0, 2'd1, 1'b0);
`endif

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL leftover_expectations: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
